// File: rtl/text_cursor_ctrl.sv
// Terminal-style text sequencer: CPU character commands become text RAM writes and cursor moves.
// Optional BS_ERASE_EN: a backspace that moves the cursor also blanks the cell it lands on.
module text_cursor_ctrl #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 5,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [7:0]        cmd_char_i,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_data_o,
  output logic              scroll_req_o,
  input  logic              scroll_done_i,
  output logic [COL_W-1:0]  cur_col_o,
  output logic [ROW_W-1:0]  cur_row_o,
  output logic              blink_reset_o
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, SCROLL} state_e;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              blink_q, blink_d;
`ifdef BS_ERASE_EN
  logic              bs_q, bs_d;
`endif

  logic [COL_W-1:0]  bs_col;
  logic [ROW_W-1:0]  bs_row;
  logic              bs_move;
  logic              printable;

  function automatic logic [ADDR_W-1:0] cellAddr(input logic [COL_W-1:0] c,
                                                 input logic [ROW_W-1:0] r);
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  // Backspace target: wraps to the end of the previous row; the home cell never moves.
  always_comb begin
    bs_move   = (col_q != '0) || (row_q != '0);
    bs_col    = (col_q == '0) ? LAST_COL : col_q - COL_W'(1);
    bs_row    = (col_q == '0) ? row_q - ROW_W'(1) : row_q;
    printable = (cmd_char_i >= 8'h20) && (cmd_char_i <= 8'h7E);
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef BS_ERASE_EN
    bs_d    = bs_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (printable) begin
            state_d = WRITE;
            addr_d  = cellAddr(col_q, row_q);
            data_d  = cmd_char_i;
`ifdef BS_ERASE_EN
            bs_d    = 1'b0;
`endif
          end else if (cmd_char_i == 8'h0D) begin
            col_d = '0;
          end else if (cmd_char_i == 8'h0A) begin
            if (row_q < LAST_ROW) row_d = row_q + ROW_W'(1);
            else                  state_d = SCROLL;
          end else if (cmd_char_i == 8'h08 && bs_move) begin
`ifdef BS_ERASE_EN
            state_d = WRITE;
            addr_d  = cellAddr(bs_col, bs_row);
            data_d  = 8'h20;
            bs_d    = 1'b1;
`else
            col_d = bs_col;
            row_d = bs_row;
`endif
          end
        end
      end
      // The cursor is still at its pre-command cell here, so the BS target is recomputed.
      WRITE: begin
        state_d = IDLE;
`ifdef BS_ERASE_EN
        if (bs_q) begin
          col_d = bs_col;
          row_d = bs_row;
        end else
`endif
        if (col_q < LAST_COL) begin
          col_d = col_q + COL_W'(1);
        end else begin
          col_d = '0;
          if (row_q < LAST_ROW) row_d = row_q + ROW_W'(1);
          else                  state_d = SCROLL;
        end
      end
      SCROLL: begin
        if (scroll_done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    blink_d = (col_d != col_q) || (row_d != row_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      blink_q <= 1'b0;
`ifdef BS_ERASE_EN
      bs_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      blink_q <= blink_d;
`ifdef BS_ERASE_EN
      bs_q    <= bs_d;
`endif
    end
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign ram_we_o      = (state_q == WRITE);
  assign scroll_req_o  = (state_q == SCROLL);
  assign ram_addr_o    = addr_q;
  assign ram_data_o    = data_q;
  assign cur_col_o     = col_q;
  assign cur_row_o     = row_q;
  assign blink_reset_o = blink_q;

endmodule
